// File: rtl/fifo_tx_arbiter.sv
// rtl/fifo_tx_arbiter.sv - round-robin arbiter sharing one FIFO transmit handshake among producers
module fifo_tx_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_rdy,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_done,
  output logic                     tx_rdy,
  input  logic                     tx_done,
  output logic [WIDTH-1:0]         in_data,
  output logic                     grant_valid,
  output logic [ID_WIDTH-1:0]      grant_id,
  output logic [15:0]              xfer_count
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] last_grant, last_grant_d;
  logic [NUM_REQ-1:0]  req_done_d;
  logic                tx_rdy_d;
  logic [WIDTH-1:0]    in_data_d;
  logic                grant_valid_d;
  logic [ID_WIDTH-1:0] grant_id_d;
  logic [15:0]         xfer_count_d;

  logic                win_found;
  logic [ID_WIDTH-1:0] win_id;
  logic [WIDTH-1:0]    win_data;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic                grant_rdy;

  // Rotating priority: indices above last_grant first, then wrap around to
  // the low indices (last_grant itself comes last).
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_rdy[i] && (i > int'(last_grant))) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
        win_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_rdy[i] && (i <= int'(last_grant))) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
        win_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign grant_onehot = NUM_REQ'(1) << grant_id;
  assign grant_rdy    = |(req_rdy & grant_onehot);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant;
    req_done_d    = req_done;
    tx_rdy_d      = tx_rdy;
    in_data_d     = in_data;
    grant_valid_d = grant_valid;
    grant_id_d    = grant_id;
    xfer_count_d  = xfer_count;
    case (state_q)
      IDLE: begin
        // A FIFO still showing done (e.g. right after reset) blocks new grants.
        if (win_found && !tx_done) begin
          in_data_d     = win_data;
          grant_id_d    = win_id;
          last_grant_d  = win_id;
          grant_valid_d = 1'b1;
          tx_rdy_d      = 1'b1;
          state_d       = REQ;
        end
      end
      REQ: begin
        if (tx_done) begin
          req_done_d   = grant_onehot;
          tx_rdy_d     = 1'b0;
          xfer_count_d = xfer_count + 16'd1;
          state_d      = ACK;
        end
      end
      ACK: begin
        if (!grant_rdy) begin
          req_done_d = '0;
          state_d    = REL;
        end
      end
      REL: begin
        if (!tx_done) begin
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_grant  <= ID_WIDTH'(NUM_REQ - 1);
      req_done    <= '0;
      tx_rdy      <= 1'b0;
      in_data     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      xfer_count  <= '0;
    end else begin
      state_q     <= state_d;
      last_grant  <= last_grant_d;
      req_done    <= req_done_d;
      tx_rdy      <= tx_rdy_d;
      in_data     <= in_data_d;
      grant_valid <= grant_valid_d;
      grant_id    <= grant_id_d;
      xfer_count  <= xfer_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// tb/tb_fifo_tx_arbiter.sv - randomized and directed bench for fifo_tx_arbiter against a round-robin model
module tb_fifo_tx_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_rdy;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_done;
  logic           tx_rdy;
  logic           tx_done;
  logic [W-1:0]   in_data;
  logic           grant_valid;
  logic [IW-1:0]  grant_id;
  logic [15:0]    xfer_count;

  always #5 clk = ~clk;

  fifo_tx_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .req_rdy(req_rdy), .req_data(req_data), .req_done(req_done),
    .tx_rdy(tx_rdy), .tx_done(tx_done), .in_data(in_data), .grant_valid(grant_valid),
    .grant_id(grant_id), .xfer_count(xfer_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int           last_g;
  logic [15:0]  exp_count;
  logic [W-1:0] exp_data;
  bit           pending;
  logic         prev_tx_rdy;
  logic [N-1:0] prev_done;
  int           done_pulses;
  int           push_cnt;
  logic [W-1:0] fifo_q[$];
  bit           fifo_full, stuck_done, rearm_en, rand_mode;
  int           cool[N];

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int d = 1; d <= N; d++) begin
      int c;
      c = (last + d) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_g      = N - 1;
    exp_count   = '0;
    pending     = 0;
    prev_tx_rdy = 1'b0;
    prev_done   = '0;
  endtask

  task automatic fifo_step();
    if (stuck_done) begin
      tx_done = 1'b1;
    end else if (tx_rdy && !tx_done && !fifo_full) begin
      fifo_q.push_back(in_data);
      push_cnt++;
      if (pending) check("push_data", in_data, exp_data);
      tx_done = 1'b1;
    end else if (!tx_rdy) begin
      tx_done = 1'b0;
    end
  endtask

  task automatic monitor();
    check("done_onehot", $onehot0(req_done), 1);
    if (tx_rdy && !prev_tx_rdy) begin
      int w;
      w = rr_pick(req_rdy, last_g);
      check("grant_id", grant_id, w);
      check("grant_valid", grant_valid, 1);
      if (w >= 0) begin
        exp_data = req_data[w*W +: W];
        last_g   = w;
      end
      check("grant_data", in_data, exp_data);
      pending = 1;
    end
    if (req_done != 0 && prev_done == 0) begin
      check("done_id", req_done, 1 << last_g);
      exp_count = exp_count + 16'd1;
      check("xfer_count", xfer_count, exp_count);
      done_pulses++;
      pending = 0;
    end
    prev_tx_rdy = tx_rdy;
    prev_done   = req_done;
  endtask

  task automatic tick();
    @(negedge clk);
    fifo_step();
    monitor();
  endtask

  task automatic prod_step();
    for (int i = 0; i < N; i++) begin
      if (req_rdy[i] && req_done[i]) begin
        if (!rand_mode || $urandom_range(1, 0) == 0) begin
          req_rdy[i] = 1'b0;
          cool[i]    = rand_mode ? int'($urandom_range(4, 0)) : 0;
        end
      end else if (rand_mode && req_rdy[i] && grant_valid && tx_rdy && grant_id == i) begin
        if ($urandom_range(15, 0) == 0) begin
          req_rdy[i] = 1'b0;
          cool[i]    = 2;
        end else if ($urandom_range(3, 0) == 0) begin
          req_data[i*W +: W] = W'($urandom);
        end
      end else if (!req_rdy[i] && rearm_en) begin
        if (cool[i] > 0) cool[i]--;
        else begin
          req_rdy[i] = 1'b1;
          if (rand_mode) req_data[i*W +: W] = W'($urandom);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_rdy    = '0;
    fifo_full  = 0;
    stuck_done = 0;
    rearm_en   = 0;
    rand_mode  = 0;
    for (int i = 0; i < N; i++) cool[i] = 0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    fifo_q.delete();
    done_pulses = 0;
    push_cnt    = 0;
  endtask

  task automatic drain(input int max_cycles);
    bit ok;
    ok       = 0;
    rearm_en = 0;
    for (int k = 0; k < max_cycles; k++) begin
      prod_step();
      tick();
      if (req_rdy == 0 && !grant_valid && req_done == 0) begin
        ok = 1;
        break;
      end
    end
    check("drain_done", ok, 1);
  endtask

  task automatic one_xfer(input int id, input logic [W-1:0] d);
    int start;
    start = done_pulses;
    req_data[id*W +: W] = d;
    req_rdy[id] = 1'b1;
    for (int k = 0; k < 30 && done_pulses == start; k++) tick();
    check("xfer_seen", done_pulses, start + 1);
    drain(30);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tx_rdy"}, tx_rdy, 0);
    check({pfx, "_req_done"}, req_done, 0);
    check({pfx, "_in_data"}, in_data, 0);
    check({pfx, "_grant_valid"}, grant_valid, 0);
    check({pfx, "_grant_id"}, grant_id, 0);
    check({pfx, "_xfer_count"}, xfer_count, 0);
  endtask

  initial begin
    int pulse;
    int bad;
    tx_done  = 1'b0;
    req_rdy  = '0;
    req_data = '0;
    rst      = 1'b1;

    // Single producer, one transfer
    do_reset();
    check_reset_outputs("rst");
    req_data[7:0] = 8'hA5;
    req_rdy = 4'b0001;
    tick();
    check("t1_tx_rdy", tx_rdy, 1);
    check("t1_in_data", in_data, 8'hA5);
    pulse = 0;
    for (int k = 0; k < 20 && grant_valid; k++) begin
      prod_step();
      tick();
      if (req_done == 4'b0001) pulse++;
    end
    check("t1_idle", grant_valid, 0);
    check("t1_done_len", pulse, 1);
    check("t1_count", xfer_count, 1);
    check("t1_fifo", fifo_q[0], 8'hA5);

    // All producers requesting continuously
    do_reset();
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    req_rdy  = 4'hF;
    rearm_en = 1;
    for (int k = 0; k < 100 && done_pulses < 8; k++) begin
      tick();
      prod_step();
    end
    check("t2_pulses", done_pulses, 8);
    for (int j = 0; j < 8; j++) check("t2_fifo_order", fifo_q[j], 8'h10 * (j % 4 + 1));
    drain(60);

    // FIFO full stalls in REQ
    do_reset();
    req_data[23:16] = 8'h5C;
    req_rdy   = 4'b0100;
    fifo_full = 1;
    tick();
    req_data[23:16] = 8'hFF;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (!tx_rdy || req_done != 0 || !grant_valid) bad++;
    end
    check("t3_stall", bad, 0);
    fifo_full = 0;
    drain(30);
    check("t3_data", fifo_q[0], 8'h5C);
    check("t3_count", xfer_count, 1);

    // Producer changes data and withdraws while in REQ
    do_reset();
    req_data[15:8] = 8'h11;
    req_rdy   = 4'b0010;
    fifo_full = 1;
    tick();
    req_data[15:8] = 8'hEE;
    req_rdy[1] = 1'b0;
    tick();
    tick();
    fifo_full = 0;
    pulse = 0;
    for (int k = 0; k < 20 && grant_valid; k++) begin
      tick();
      if (req_done[1]) pulse++;
    end
    check("t4_ack_len", pulse, 1);
    check("t4_data", fifo_q[0], 8'h11);
    check("t4_pulses", done_pulses, 1);

    // Reset in REQ with tx_done high, then done-phase guard
    do_reset();
    req_data[23:16] = 8'h77;
    req_data[7:0]   = 8'h01;
    req_rdy = 4'b0100;
    tick();
    check("t5_in_req", tx_rdy, 1);
    rst        = 1'b1;
    stuck_done = 1;
    tick();
    model_reset();
    check_reset_outputs("t5");
    rst     = 1'b0;
    req_rdy = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_no_grant", tx_rdy | grant_valid, 0);
    end
    stuck_done = 0;
    tick();
    check("t5_still_idle", tx_rdy, 0);
    tick();
    check("t5_tx_rdy", tx_rdy, 1);
    check("t5_first_id", grant_id, 0);
    drain(60);

    // Transfer counter wrap
    do_reset();
    force dut.xfer_count = 16'hFFFE;
    #1;
    release dut.xfer_count;
    exp_count = 16'hFFFE;
    check("t6_preload", xfer_count, 16'hFFFE);
    one_xfer(3, 8'h3C);
    check("t6_ffff", xfer_count, 16'hFFFF);
    one_xfer(1, 8'hC3);
    check("t6_wrap", xfer_count, 16'h0000);

    // Randomized traffic with random FIFO backpressure
    do_reset();
    rand_mode = 1;
    rearm_en  = 1;
    req_data  = $urandom;
    for (int k = 0; k < 3000; k++) begin
      tick();
      prod_step();
      if ($urandom_range(7, 0) == 0) fifo_full = !fifo_full;
    end
    fifo_full = 0;
    drain(300);
    check("rnd_push_vs_done", push_cnt, done_pulses);
    check("rnd_count", xfer_count, exp_count);
    check("rnd_activity", done_pulses > 50, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
